// File: rtl/bht_update_sched_pkg.sv
// Shared types for the BHT update scheduler: index type, queued update record
// and scheduler state encoding.
package bht_update_sched_pkg;

  localparam int BHT_ENTRIES = 32;
  localparam int BHT_IDX_W   = 5;

  typedef logic [BHT_IDX_W-1:0] lc3b_p_index;

  typedef struct packed {
    lc3b_p_index index;
    logic        taken;
  } bht_upd_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bht_sched_state_t;

endpackage

// File: rtl/bht_update_sched_if.sv
// Resolve-stage handshake into the BHT update scheduler.
interface bht_update_sched_if;
  import bht_update_sched_pkg::*;

  logic        resolve_valid;
  lc3b_p_index resolve_index;
  logic        resolve_taken;
  logic        resolve_ready;

  modport master (output resolve_valid, resolve_index, resolve_taken,
                  input  resolve_ready);
  modport slave  (input  resolve_valid, resolve_index, resolve_taken,
                  output resolve_ready);
endinterface

// File: rtl/bht_upd_fifo.sv
// Circular buffer of pending BHT updates. Besides the head it exposes every
// slot with a live flag so the top can match fetch lookups against all
// queued updates in parallel.
module bht_upd_fifo
  import bht_update_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  bht_upd_t                      push_data,
  input  logic                          pop,
  output logic [CW-1:0]                 count,
  output bht_upd_t                      head,
  output logic [DEPTH-1:0]              ent_valid,
  output lc3b_p_index [DEPTH-1:0]       ent_index
);

  bht_upd_t [DEPTH-1:0] mem;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;

  // Storage carries no reset; only slots covered by count are ever consumed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] off;
    assign off          = PW'(i) - rd_ptr;
    assign ent_valid[i] = CW'(off) < count;
    assign ent_index[i] = mem[i].index;
  end

endmodule

// File: rtl/bht_update_sched.sv
// BHT write sequencer: clears the whole table after reset or on reinit,
// then drains queued branch resolutions into the BHT write port, one per
// cycle, and flags fetch lookups that would read soon-to-change history.
module bht_update_sched
  import bht_update_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = BHT_ENTRIES,
  parameter int IDX_W   = BHT_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  bht_update_sched_if.slave    res,
  input  logic                 upd_hold,
  input  logic                 reinit,
  input  logic [IDX_W-1:0]     lookup_index,
  output logic                 lookup_stale,
  output logic                 bht_we,
  output logic                 bht_clear,
  output logic [IDX_W-1:0]     bht_index,
  output logic                 bht_taken,
  output logic                 init_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  bht_sched_state_t       state, state_nx;
  logic [IDX_W-1:0]       init_cnt, init_cnt_nx;
  logic                   ready, push, pop;
  logic [CW-1:0]          count;
  bht_upd_t               head;
  bht_upd_t               push_data;
  logic [DEPTH-1:0]       ent_valid;
  lc3b_p_index [DEPTH-1:0] ent_index;
  logic [DEPTH-1:0]       hit;
  logic                   nonempty;

  assign nonempty  = count != '0;
  assign push_data = '{index: res.resolve_index, taken: res.resolve_taken};

  bht_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head),
    .ent_valid (ent_valid),
    .ent_index (ent_index)
  );

  // State and clear-walk counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
    end
  end

  // Next state, acceptance and drain decisions. Ready depends only on the
  // state and occupancy, so a full FIFO stays closed even in a pop cycle.
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    ready       = 1'b0;
    pop         = 1'b0;
    case (state)
      INIT: begin
        if (reinit) begin
          init_cnt_nx = '0;
        end else if (init_cnt == IDX_W'(ENTRIES - 1)) begin
          state_nx    = RUN;
          init_cnt_nx = '0;
        end else begin
          init_cnt_nx = init_cnt + 1'b1;
        end
      end
      RUN: begin
        ready = count != CW'(DEPTH);
        pop   = nonempty && !upd_hold;
        if (reinit) state_nx = DRAIN;
      end
      DRAIN: begin
        pop = nonempty && !upd_hold;
        if (!nonempty) begin
          state_nx    = INIT;
          init_cnt_nx = '0;
        end
      end
      default: begin
        state_nx    = INIT;
        init_cnt_nx = '0;
      end
    endcase
    push = res.resolve_valid && ready;
  end

  assign res.resolve_ready = ready;

  // Registered BHT write port: clear walk in INIT, otherwise FIFO head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bht_we    <= 1'b0;
      bht_clear <= 1'b0;
      bht_index <= '0;
      bht_taken <= 1'b0;
    end else if (state == INIT) begin
      bht_we    <= 1'b1;
      bht_clear <= 1'b1;
      bht_index <= init_cnt;
      bht_taken <= 1'b0;
    end else if (pop) begin
      bht_we    <= 1'b1;
      bht_clear <= 1'b0;
      bht_index <= IDX_W'(head.index);
      bht_taken <= head.taken;
    end else begin
      bht_we    <= 1'b0;
      bht_clear <= 1'b0;
    end
  end

  // Lookup matches against every queued update and the write in flight.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = ent_valid[i] && (IDX_W'(ent_index[i]) == lookup_index);
  end

  assign lookup_stale = (state != RUN) || (|hit) ||
                        (bht_we && !bht_clear && (bht_index == lookup_index));
  assign init_done    = state == RUN;

endmodule
